int_to_float_seq: RTL and testbench



---
 rtl/int_to_float_seq_pkg.sv | 14 +
 rtl/int_to_float_seq_if.sv | 19 +
 rtl/int_to_float_seq_fp_round_pack.sv | 27 ++
 rtl/int_to_float_seq.sv | 79 +++++++
 tb/tb_int_to_float_seq.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/int_to_float_seq_pkg.sv
// int_to_float_seq_pkg: shared FP/integer widths and converter state encoding
package int_to_float_seq_pkg;
    localparam int FP_EXP_BIAS = 127;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MANT_W   = 23;
    localparam int INT_W       = 32;
    localparam int CNT_W       = 5;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/int_to_float_seq_if.sv
// int_to_float_seq_if: valid/ready operand and result channels of the converter
interface int_to_float_seq_if;
    logic                                  in_valid;
    logic                                  in_ready;
    logic [int_to_float_seq_pkg::INT_W-1:0] in_data;
    logic                                  in_signed;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [int_to_float_seq_pkg::INT_W-1:0] out_data;
    logic                                  out_inexact;
    modport master (
        output in_valid, in_data, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_inexact
    );
    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_inexact
    );
endinterface

// File: rtl/int_to_float_seq_fp_round_pack.sv
// int_to_float_seq_fp_round_pack: rounds a normalized magnitude and packs an IEEE-754 single
module int_to_float_seq_fp_round_pack
    import int_to_float_seq_pkg::*;
#(
    parameter bit ROUND_NEAREST = 1'b1
) (
    input  logic             i_sign,
    input  logic [CNT_W-1:0] i_count,
    input  logic [INT_W-2:0] i_frac,
    output logic [INT_W-1:0] o_word,
    output logic             o_inexact
);
    localparam int EXP_TOP = FP_EXP_BIAS + INT_W - 1;
    logic [FP_EXP_W-1:0]  w_exp;
    logic [FP_MANT_W-1:0] w_mant;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_inc;
    assign w_exp    = FP_EXP_W'(EXP_TOP - int'(i_count));
    assign w_mant   = i_frac[INT_W-2 -: FP_MANT_W];
    assign w_guard  = i_frac[INT_W-2-FP_MANT_W];
    assign w_sticky = |i_frac[INT_W-3-FP_MANT_W:0];
    assign w_inc    = ROUND_NEAREST && w_guard && (w_sticky || w_mant[0]);
    // a mantissa carry-out ripples straight into the exponent field
    assign o_word    = {i_sign, {w_exp, w_mant} + (FP_EXP_W + FP_MANT_W)'(w_inc)};
    assign o_inexact = w_guard | w_sticky;
endmodule

// File: rtl/int_to_float_seq.sv
// int_to_float_seq: sequential 32-bit integer to IEEE-754 single converter with a shift-loop normalizer
module int_to_float_seq
    import int_to_float_seq_pkg::*;
#(
    parameter bit ROUND_NEAREST = 1'b1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    int_to_float_seq_if.slave bus
);
    state_t           r_state;
    state_t           w_state_next;
    logic             r_sign;
    logic             r_inexact;
    logic [INT_W-1:0] r_mag;
    logic [INT_W-1:0] r_out_data;
    logic [CNT_W-1:0] r_count;
    logic             w_sign_in;
    logic [INT_W-1:0] w_mag_in;
    logic [INT_W-1:0] w_word;
    logic             w_inexact;
    assign w_sign_in = bus.in_signed & bus.in_data[INT_W-1];
    assign w_mag_in  = w_sign_in ? -bus.in_data : bus.in_data;
    assign bus.in_ready    = r_state == S_IDLE;
    assign bus.out_valid   = r_state == S_DONE;
    assign bus.out_data    = r_out_data;
    assign bus.out_inexact = r_inexact;
    int_to_float_seq_fp_round_pack #(
        .ROUND_NEAREST(ROUND_NEAREST)
    ) u_round_pack (
        .i_sign   (r_sign),
        .i_count  (r_count),
        .i_frac   (r_mag[INT_W-2:0]),
        .o_word   (w_word),
        .o_inexact(w_inexact)
    );
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = bus.in_valid ? ((w_mag_in == '0) ? S_DONE : S_NORM) : S_IDLE;
            S_NORM:  w_state_next = r_mag[INT_W-1] ? S_ROUND : S_NORM;
            S_ROUND: w_state_next = S_DONE;
            S_DONE:  w_state_next = bus.out_ready ? S_IDLE : S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sign     <= 1'b0;
            r_mag      <= '0;
            r_count    <= '0;
            r_out_data <= '0;
            r_inexact  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_sign     <= w_sign_in;
                    r_mag      <= w_mag_in;
                    r_count    <= '0;
                    r_out_data <= '0;
                    r_inexact  <= 1'b0;
                end
                S_NORM: if (!r_mag[INT_W-1]) begin
                    r_mag   <= r_mag << 1;
                    r_count <= r_count + CNT_W'(1);
                end
                S_ROUND: begin
                    r_out_data <= w_word;
                    r_inexact  <= w_inexact;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_int_to_float_seq.sv
// tb_int_to_float_seq: directed and model-checked bench for both rounding modes of int_to_float_seq
module tb_int_to_float_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    int_to_float_seq_if bus_rn ();
    int_to_float_seq_if bus_tr ();

    assign bus_tr.in_valid  = bus_rn.in_valid;
    assign bus_tr.in_data   = bus_rn.in_data;
    assign bus_tr.in_signed = bus_rn.in_signed;
    assign bus_tr.out_ready = bus_rn.out_ready;

    int_to_float_seq #(.ROUND_NEAREST(1'b1)) dut_rn (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus_rn));
    int_to_float_seq #(.ROUND_NEAREST(1'b0)) dut_tr (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus_tr));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] drn;
        logic [31:0] dtr;
        logic        ix;
        int          lat;
        int          acc;
        logic        seen;
    } exp_t;

    exp_t exq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // latency counts edges after the accepting edge; a zero result is visible in the very next cycle
    function automatic exp_t model(input logic [31:0] d, input logic s, input int acc);
        exp_t        e;
        logic        neg;
        logic [63:0] m, qt, qr, rem, half;
        int          p, pr, sh;
        neg = s && d[31];
        m = neg ? (64'h1_0000_0000 - {32'b0, d}) : {32'b0, d};
        e.acc = acc;
        e.seen = 1'b0;
        if (m == 0) begin
            e.drn = 32'h0; e.dtr = 32'h0; e.ix = 1'b0; e.lat = 0;
            return e;
        end
        p = 0;
        for (int i = 0; i < 33; i++) if (m[i]) p = i;
        if (p <= 23) begin
            qt = m << (23 - p);
            rem = 0;
            half = 0;
        end else begin
            sh = p - 23;
            qt = m >> sh;
            rem = m & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
        end
        qr = qt + ((rem != 0 && (rem > half || (rem == half && qt[0]))) ? 64'd1 : 64'd0);
        pr = p;
        if (qr == 64'h100_0000) begin
            qr = qr >> 1;
            pr = p + 1;
        end
        e.drn = {neg, 8'(pr + 127), qr[22:0]};
        e.dtr = {neg, 8'(p + 127), qt[22:0]};
        e.ix = rem != 0;
        e.lat = 33 - p;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exq.delete();
        end else begin
            if (bus_rn.in_valid && bus_rn.in_ready)
                exq.push_back(model(bus_rn.in_data, bus_rn.in_signed, cyc + 1));
            if (bus_rn.out_valid || bus_tr.out_valid) begin
                if (exq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got out_valid with data %h expected none", bus_rn.out_data);
                end else begin
                    chk("rn_out_valid", 32'(bus_rn.out_valid), 32'd1);
                    chk("tr_out_valid", 32'(bus_tr.out_valid), 32'd1);
                    chk("rn_out_data", bus_rn.out_data, exq[0].drn);
                    chk("tr_out_data", bus_tr.out_data, exq[0].dtr);
                    chk("rn_inexact", 32'(bus_rn.out_inexact), 32'(exq[0].ix));
                    chk("tr_inexact", 32'(bus_tr.out_inexact), 32'(exq[0].ix));
                    chk("in_ready_while_done", 32'(bus_rn.in_ready | bus_tr.in_ready), 32'd0);
                    if (!exq[0].seen) chk("latency", 32'(cyc - exq[0].acc), 32'(exq[0].lat));
                    exq[0].seen = 1'b1;
                    if (bus_rn.out_ready) void'(exq.pop_front());
                end
            end
        end
    end

    task automatic convert(input logic [31:0] d, input logic s, input int hold, input logic lit,
                           input logic [31:0] e_rn, input logic [31:0] e_tr, input logic e_ix, input int e_lat);
        int n;
        @(posedge clk); #1;
        bus_rn.in_valid = 1'b1;
        bus_rn.in_data = d;
        bus_rn.in_signed = s;
        @(posedge clk); #1;
        bus_rn.in_valid = 1'b0;
        bus_rn.in_data = $urandom;
        bus_rn.in_signed = 1'($urandom_range(0, 1));
        n = 0;
        while (!bus_rn.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus_rn.out_valid) begin
            checks++;
            failures++;
            $display("FAIL timeout: got no out_valid for input %h expected one within 40 cycles", d);
            return;
        end
        if (lit) begin
            chk("lit_rn_data", bus_rn.out_data, e_rn);
            chk("lit_tr_data", bus_tr.out_data, e_tr);
            chk("lit_inexact", 32'(bus_rn.out_inexact), 32'(e_ix));
            chk("lit_latency", 32'(n), 32'(e_lat));
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        bus_rn.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_rn.out_ready = 1'b0;
        chk("in_ready_after_accept", 32'(bus_rn.in_ready & bus_tr.in_ready), 32'd1);
        chk("out_valid_after_accept", 32'(bus_rn.out_valid | bus_tr.out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        bus_rn.in_valid = 1'b0;
        bus_rn.in_data = 32'h0;
        bus_rn.in_signed = 1'b0;
        bus_rn.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(bus_rn.in_ready & bus_tr.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus_rn.out_valid | bus_tr.out_valid), 32'd0);
        chk("reset_out_data", bus_rn.out_data | bus_tr.out_data, 32'h0);
        chk("reset_inexact", 32'(bus_rn.out_inexact | bus_tr.out_inexact), 32'd0);
        rst = 1'b0;
        convert(32'h0000_0001, 1'b1, 0, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 33);
        convert(32'hFFFF_FFFF, 1'b1, 0, 1'b1, 32'hBF80_0000, 32'hBF80_0000, 1'b0, 33);
        convert(32'hFFFF_FFFF, 1'b0, 0, 1'b1, 32'h4F80_0000, 32'h4F7F_FFFF, 1'b1, 2);
        convert(32'h8000_0000, 1'b1, 0, 1'b1, 32'hCF00_0000, 32'hCF00_0000, 1'b0, 2);
        convert(32'h8000_0000, 1'b0, 0, 1'b1, 32'h4F00_0000, 32'h4F00_0000, 1'b0, 2);
        convert(32'h0100_0001, 1'b0, 0, 1'b1, 32'h4B80_0000, 32'h4B80_0000, 1'b1, 9);
        convert(32'h0100_0003, 1'b0, 0, 1'b1, 32'h4B80_0002, 32'h4B80_0001, 1'b1, 9);
        convert(32'h0000_0000, 1'b0, 0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 0);
        convert(32'h0000_0000, 1'b1, 0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 0);
        convert(32'h00FF_FFFF, 1'b0, 0, 1'b1, 32'h4B7F_FFFF, 32'h4B7F_FFFF, 1'b0, 10);
        convert(32'hFFFF_FFFD, 1'b1, 10, 1'b1, 32'hC040_0000, 32'hC040_0000, 1'b0, 32);
        for (int i = 0; i < 16; i++) begin
            r = $urandom;
            convert(r >> $urandom_range(0, 31), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                    1'b0, 32'h0, 32'h0, 1'b0, 0);
        end
        @(posedge clk); #1;
        bus_rn.in_valid = 1'b1;
        bus_rn.in_data = 32'h0000_0001;
        bus_rn.in_signed = 1'b0;
        @(posedge clk); #1;
        bus_rn.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_out_valid", 32'(bus_rn.out_valid | bus_tr.out_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(bus_rn.in_ready & bus_tr.in_ready), 32'd1);
        chk("rst_mid_out_data", bus_rn.out_data | bus_tr.out_data, 32'h0);
        chk("rst_mid_inexact", 32'(bus_rn.out_inexact | bus_tr.out_inexact), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("no_stale_out_valid", 32'(bus_rn.out_valid | bus_tr.out_valid), 32'd0);
        convert(32'h0000_0006, 1'b0, 1, 1'b1, 32'h40C0_0000, 32'h40C0_0000, 1'b0, 31);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
